// File: rtl/keccak_round_ctrl_if.sv
// rtl/keccak_round_ctrl_if.sv - request/round/result signals between Keccak round sequencer and its peers
interface keccak_round_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic        load_en;
    logic        round_en;
    logic [4:0]  round_idx;
    logic        last_round;
    logic [63:0] iota_rc;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output in_valid, stall, out_ready,
        input  in_ready, load_en, round_en, round_idx, last_round, iota_rc, out_valid
    );

    modport slave (
        input  in_valid, stall, out_ready,
        output in_ready, load_en, round_en, round_idx, last_round, iota_rc, out_valid
    );
endinterface

// File: rtl/keccak_round_ctrl.sv
// rtl/keccak_round_ctrl.sv - Keccak-f[1600] round sequencer with 7-lane rc(t) LFSR iota constant generator
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS = 24
) (
    input logic               clk,
    input logic               rst,
    keccak_round_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [4:0]      cnt;
    logic [6:0][7:0] lane;
    logic [6:0][7:0] lane_adv;
    logic [6:0][7:0] lane_seed;
    logic            advance;
    logic            restart;

    // One rc(t) step on x^8+x^6+x^5+x^4+1; bit0 is the current rc output.
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
    endfunction

    function automatic logic [7:0] lfsr_step7(input logic [7:0] r);
        logic [7:0] v;
        v = r;
        for (int i = 0; i < 7; i++) begin
            v = lfsr_step(v);
        end
        return v;
    endfunction

    // Lane j starts j steps ahead, so after r rounds it sits at step j+7r.
    always_comb begin
        for (int j = 0; j < 7; j++) begin
            lane_seed[j] = 8'h01 << j;
            lane_adv[j]  = lfsr_step7(lane[j]);
        end
    end

    assign advance = (state == ST_ROUND) && !bus.stall;
    assign restart = (state == ST_DONE) && bus.out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.in_valid) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ROUND;
            ST_ROUND: if (advance && cnt == LAST_IDX) state_nxt = ST_DONE;
            ST_DONE:  if (bus.out_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // The final round re-seeds immediately so DONE already presents RC[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            lane  <= lane_seed;
        end else begin
            state <= state_nxt;
            if (advance) begin
                if (cnt == LAST_IDX) begin
                    cnt  <= 5'd0;
                    lane <= lane_seed;
                end else begin
                    cnt  <= cnt + 5'd1;
                    lane <= lane_adv;
                end
            end else if (restart) begin
                cnt  <= 5'd0;
                lane <= lane_seed;
            end
        end
    end

    always_comb begin
        bus.iota_rc = 64'd0;
        for (int j = 0; j < 7; j++) begin
            bus.iota_rc[(1 << j) - 1] = lane[j][0];
        end
    end

    assign bus.in_ready   = (state == ST_IDLE);
    assign bus.load_en    = (state == ST_LOAD);
    assign bus.round_en   = advance;
    assign bus.round_idx  = cnt;
    assign bus.last_round = advance && (cnt == LAST_IDX);
    assign bus.out_valid  = (state == ST_DONE);

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// tb/tb_keccak_round_ctrl.sv - self-checking bench for keccak_round_ctrl against a round-level reference model
module tb_keccak_round_ctrl;

    localparam int NR = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    keccak_round_ctrl_if bus();
    keccak_round_ctrl_if bus1();

    keccak_round_ctrl #(.NUM_ROUNDS(NR)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    keccak_round_ctrl #(.NUM_ROUNDS(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    logic [63:0] rc_tab [NR];

    // Model: phase 0 idle, 1 load, 2 rounds, 3 result waiting; k = rounds completed.
    int ph = 0;
    int k  = 0;
    int cyc = 0;
    int ov_cyc = -1;
    int n_round_en = 0;
    bit ov_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // rc(t) as the constant term of x^t mod (x^8+x^6+x^5+x^4+1).
    function automatic logic rc_bit(input int t);
        logic [8:0] p;
        p = 9'h001;
        for (int i = 0; i < t % 255; i++) begin
            p = p << 1;
            if (p[8]) p = p ^ 9'h171;
        end
        return p[0];
    endfunction

    task automatic step(input logic iv, input logic st, input logic ordy, input logic r);
        logic [63:0] exp_rc;
        bit exp_ren;
        bus.in_valid  = iv;
        bus.stall     = st;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        exp_ren = (ph == 2) && !st;
        exp_rc  = (ph == 2) ? rc_tab[k] : rc_tab[0];
        chk("in_ready",   64'(bus.in_ready),   64'(ph == 0));
        chk("load_en",    64'(bus.load_en),    64'(ph == 1));
        chk("round_en",   64'(bus.round_en),   64'(exp_ren));
        chk("round_idx",  64'(bus.round_idx),  (ph == 2) ? 64'(k) : 64'd0);
        chk("last_round", 64'(bus.last_round), 64'(exp_ren && k == NR - 1));
        chk("iota_rc",    bus.iota_rc,         exp_rc);
        chk("out_valid",  64'(bus.out_valid),  64'(ph == 3));
        if (bus.round_en) begin
            n_round_en++;
            case (bus.round_idx)
                5'd0:  chk("rc0_lit",  bus.iota_rc, 64'h0000000000000001);
                5'd1:  chk("rc1_lit",  bus.iota_rc, 64'h0000000000008082);
                5'd2:  chk("rc2_lit",  bus.iota_rc, 64'h800000000000808A);
                5'd3:  chk("rc3_lit",  bus.iota_rc, 64'h8000000080008000);
                5'd23: chk("rc23_lit", bus.iota_rc, 64'h8000000080008008);
                default: ;
            endcase
        end
        if (bus.last_round) chk("last_rc23", bus.iota_rc, 64'h8000000080008008);
        if (bus.out_valid) begin
            ov_seen = 1;
            if (ov_cyc < 0) ov_cyc = cyc;
        end
        @(posedge clk);
        if (r) begin
            ph = 0;
            k  = 0;
        end else begin
            case (ph)
                0: if (iv) ph = 1;
                1: begin ph = 2; k = 0; end
                2: if (!st) begin
                       if (k == NR - 1) begin ph = 3; k = 0; end
                       else k++;
                   end
                3: if (ordy) ph = 0;
                default: ph = 0;
            endcase
        end
        @(negedge clk);
        cyc++;
    endtask

    // Accept now, then run unstalled until out_valid; returns accept-to-out_valid latency.
    task automatic run_request(input logic ordy, output int lat);
        int t0;
        ov_cyc = -1;
        n_round_en = 0;
        t0 = cyc;
        step(1'b1, 1'b0, ordy, 1'b0);
        for (int i = 0; i < 60 && ov_cyc < 0; i++) step(1'b0, 1'b0, ordy, 1'b0);
        lat = (ov_cyc < 0) ? -1 : ov_cyc - t0;
    endtask

    int lat;
    int t0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            rc_tab[i] = 64'd0;
            for (int j = 0; j < 7; j++) rc_tab[i][(1 << j) - 1] = rc_bit(j + 7 * i);
        end
        bus.in_valid = 0; bus.stall = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.stall = 0; bus1.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        run_request(1'b1, lat);
        chk("latency_plain", 64'(lat), 64'd26);
        chk("round_count", 64'(n_round_en), 64'd24);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Stall three cycles while round 5 is pending.
        ov_cyc = -1;
        t0 = cyc;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("stall_idx_held", 64'(bus.round_idx), 64'd5);
        chk("stall_rc5_held", bus.iota_rc, rc_tab[5]);
        for (int i = 0; i < 60 && ov_cyc < 0; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("latency_stall", 64'(ov_cyc - t0), 64'd29);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Consumer back-pressure with in_valid held high.
        ov_cyc = -1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60 && ov_cyc < 0; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_request(1'b1, lat);
        chk("latency_second", 64'(lat), 64'd26);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset pulse while round 10 is pending.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (11) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_idx", 64'(bus.round_idx), 64'd10);
        ov_seen = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_no_out_valid", 64'(ov_seen), 64'd0);
        run_request(1'b1, lat);
        chk("latency_after_rst", 64'(lat), 64'd26);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0));
        end

        // Single-round configuration.
        bus.in_valid = 0;
        rst = 0;
        bus1.out_ready = 0;
        bus1.in_valid = 1;
        #1;
        chk("nr1_in_ready", 64'(bus1.in_ready), 64'd1);
        @(posedge clk); @(negedge clk);
        bus1.in_valid = 0;
        #1;
        chk("nr1_load_en", 64'(bus1.load_en), 64'd1);
        @(posedge clk); @(negedge clk);
        #1;
        chk("nr1_round_en", 64'(bus1.round_en), 64'd1);
        chk("nr1_last_round", 64'(bus1.last_round), 64'd1);
        chk("nr1_round_idx", 64'(bus1.round_idx), 64'd0);
        chk("nr1_rc0", bus1.iota_rc, 64'h1);
        chk("nr1_no_ov_yet", 64'(bus1.out_valid), 64'd0);
        @(posedge clk); @(negedge clk);
        bus1.out_ready = 1;
        #1;
        chk("nr1_out_valid", 64'(bus1.out_valid), 64'd1);
        chk("nr1_round_en_off", 64'(bus1.round_en), 64'd0);
        @(posedge clk); @(negedge clk);
        #1;
        chk("nr1_out_valid_clr", 64'(bus1.out_valid), 64'd0);
        chk("nr1_idle", 64'(bus1.in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
